// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - 4-bit operation codes driven by the EX stage
//   - FSM state encoding used by the top level
//   - small op-class decode helpers and a conditional two's-complement negate
package hilo_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MADDU = 4'd4;
    localparam logic [3:0] OP_MSUB  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Widest value the negate helper handles: a full 2*WIDTH product with WIDTH<=32.
    localparam int MAX_W = 64;

    // Two's-complement negate when neg=1, pass-through otherwise. Callers
    // zero-extend narrower values and keep only their low bits, which is
    // exact because negation is modular.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? ((~v) + 64'd1) : v;
    endfunction

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MSUBU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: request/response bundle between the EX stage and the
// HI/LO multiply/divide unit.
//   start/op/a/b/abort : request side, driven by the core (master)
//   busy/done/div_zero : handshake status back to the core
//   hi/lo              : architectural HI/LO registers (MFHI/MFLO sources)
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit_iter_core.sv
// muldiv_iter_core: iterative unsigned datapath, one bit per step.
//   load      : capture operands (magnitudes) and select mode; counter=WIDTH
//   step      : perform one shift-add (multiply) or restoring (divide) step
//   div_mode  : 0 = multiply, 1 = divide (sampled on load)
//   op_a/op_b : multiplier/multiplicand, or dividend/divisor
//   finish    : high during the last step (counter==1)
//   product   : 2*WIDTH result of a multiply
//   quotient/remainder : divide results
// A single 2*WIDTH register serves both modes: for multiply it holds the
// partial product over the remaining multiplier bits; for divide the upper
// half is the partial remainder and the lower half shifts the dividend out
// while quotient bits shift in.
module muldiv_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               finish,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic               mode_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_reg};
        if (!mode_reg) begin
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            // Partial remainder < divisor, so a non-negative trial fits in WIDTH bits.
            acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            opb_reg  <= '0;
            mode_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (load) begin
            acc_reg  <= {{WIDTH{1'b0}}, op_a};
            opb_reg  <= op_b;
            mode_reg <= div_mode;
            cnt_reg  <= CNT_W'(WIDTH);
        end else if (step) begin
            acc_reg <= acc_next;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign finish    = (cnt_reg == CNT_W'(1));
    assign product   = acc_reg;
    assign quotient  = acc_reg[WIDTH-1:0];
    assign remainder = acc_reg[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: owns the HI/LO pair; runs iterative multiply/divide.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request (start/op/a/b/abort) and status (busy/done/div_zero/hi/lo)
// The FSM latches operand magnitudes and result signs, lets the iterative
// core run WIDTH steps, then applies sign correction and accumulation in FIX.
// MTHI/MTLO complete in a single edge without raising busy.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    hilo_muldiv_unit_if.slave bus
);

    state_t           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [3:0]       op_reg;
    logic             neg_q_reg;   // product / quotient sign
    logic             neg_r_reg;   // remainder sign (dividend sign)
    logic             dz_reg;
    logic [WIDTH-1:0] a_raw_reg;

    logic               start_ok;
    logic               sgn_op;
    logic               neg_a;
    logic               neg_b;
    logic [MAX_W-1:0]   a_mag_full;
    logic [MAX_W-1:0]   b_mag_full;
    logic               core_load;
    logic               core_step;
    logic               core_finish;
    logic [2*WIDTH-1:0] core_product;
    logic [WIDTH-1:0]   core_quotient;
    logic [WIDTH-1:0]   core_remainder;
    logic [MAX_W-1:0]   prod_full;
    logic [MAX_W-1:0]   quo_full;
    logic [MAX_W-1:0]   rem_full;
    logic [2*WIDTH-1:0] mul_result;
    logic               unused_hi_bits;

    // Start is only honoured from IDLE (busy low), and abort takes priority.
    assign start_ok  = bus.start && !bus.abort && (state_reg == IDLE);
    assign sgn_op    = op_is_signed(bus.op);
    assign neg_a     = sgn_op && bus.a[WIDTH-1];
    assign neg_b     = sgn_op && bus.b[WIDTH-1];
    assign a_mag_full = cond_neg(MAX_W'(bus.a), neg_a);
    assign b_mag_full = cond_neg(MAX_W'(bus.b), neg_b);

    // A zero divisor skips the datapath entirely and goes straight to FIX.
    assign core_load = start_ok &&
                       (op_is_mul(bus.op) || (op_is_div(bus.op) && (bus.b != '0)));
    assign core_step = ((state_reg == MUL) || (state_reg == DIV)) && !bus.abort;

    muldiv_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .step      (core_step),
        .div_mode  (op_is_div(bus.op)),
        .op_a      (a_mag_full[WIDTH-1:0]),
        .op_b      (b_mag_full[WIDTH-1:0]),
        .finish    (core_finish),
        .product   (core_product),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

    // FIX-stage arithmetic: sign correction, then modular accumulate into {HI,LO}.
    // The most-negative / -1 case needs no special handling: its magnitude
    // quotient negates back to itself.
    assign prod_full = cond_neg(MAX_W'(core_product), neg_q_reg);
    assign quo_full  = cond_neg(MAX_W'(core_quotient), neg_q_reg);
    assign rem_full  = cond_neg(MAX_W'(core_remainder), neg_r_reg);

    always_comb begin
        mul_result = prod_full[2*WIDTH-1:0];
        case (op_reg)
            OP_MADD, OP_MADDU: mul_result = {hi_reg, lo_reg} + prod_full[2*WIDTH-1:0];
            OP_MSUB, OP_MSUBU: mul_result = {hi_reg, lo_reg} - prod_full[2*WIDTH-1:0];
            default:           mul_result = prod_full[2*WIDTH-1:0];
        endcase
    end

    // Upper bits of the widened helper results are don't-care for WIDTH<32.
    assign unused_hi_bits = ^{a_mag_full, b_mag_full, prod_full, quo_full, rem_full};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            op_reg       <= OP_NOP;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dz_reg       <= 1'b0;
            a_raw_reg    <= '0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        op_reg    <= bus.op;
                        neg_q_reg <= neg_a ^ neg_b;
                        neg_r_reg <= neg_a;
                        a_raw_reg <= bus.a;
                        dz_reg    <= (bus.b == '0);
                        if (bus.op == OP_MTHI) begin
                            hi_reg <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_reg <= bus.a;
                        end else if (op_is_mul(bus.op)) begin
                            state_reg <= MUL;
                            busy_reg  <= 1'b1;
                        end else if (op_is_div(bus.op)) begin
                            state_reg <= (bus.b == '0) ? FIX : DIV;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    if (bus.abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (core_finish) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (!bus.abort) begin
                        done_reg <= 1'b1;
                        if (op_is_div(op_reg)) begin
                            if (dz_reg) begin
                                hi_reg       <= a_raw_reg;
                                lo_reg       <= '1;
                                div_zero_reg <= 1'b1;
                            end else begin
                                hi_reg <= rem_full[WIDTH-1:0];
                                lo_reg <= quo_full[WIDTH-1:0];
                            end
                        end else begin
                            {hi_reg, lo_reg} <= mul_result;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors with hand-computed HI/LO results,
// latency, handshake, abort and asynchronous-reset behaviour.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Present a one-cycle request; returns at the negedge of cycle 1.
    task automatic pulse_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = OP_NOP;
    endtask

    // Called at cycle 1; lat is the cycle index at which done is seen.
    task automatic wait_done(output int lat, output logic dz, output int busy_cnt);
        logic got;
        got      = 1'b0;
        lat      = 1;
        dz       = 1'b0;
        busy_cnt = 0;
        while (!got && lat < 100) begin
            if (bus.done) begin
                got = 1'b1;
                dz  = bus.div_zero;
            end else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
                lat++;
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    int   lat;
    int   bc;
    int   done_cnt;
    logic dz;

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.a     = '0;
        bus.b     = '0;
        bus.abort = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;

        // MULT -2 * 3 = -6
        pulse_start(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_c1", 64'(bus.busy), 64'd1);
        wait_done(lat, dz, bc);
        check("mult_latency", 64'(lat), 64'd34);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        check("mult_busy_at_done", 64'(bus.busy), 64'd0);
        check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult_dz", 64'(dz), 64'd0);
        @(negedge clk);
        check("mult_done_pulse", 64'(bus.done), 64'd0);

        // MULTU max * max
        pulse_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, dz, bc);
        check("multu_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

        // MTHI / MTLO then MADD / MSUB
        pulse_start(OP_MTHI, 32'd5, 32'd0);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_hi", 64'(bus.hi), 64'd5);
        pulse_start(OP_MTLO, 32'd7, 32'd0);
        check("mtlo_done", 64'(bus.done), 64'd0);
        check("mtlo_lo", 64'(bus.lo), 64'd7);
        pulse_start(OP_MADD, 32'd2, 32'd3);
        wait_done(lat, dz, bc);
        check("madd_hilo", {bus.hi, bus.lo}, {32'd5, 32'd13});
        pulse_start(OP_MSUB, 32'd2, 32'd3);
        wait_done(lat, dz, bc);
        check("msub_hilo", {bus.hi, bus.lo}, {32'd5, 32'd7});

        // DIV -7 / 2 -> q=-3, r=-1
        pulse_start(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, dz, bc);
        check("div_latency", 64'(lat), 64'd34);
        check("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_dz", 64'(dz), 64'd0);

        // DIVU 7 / 0
        pulse_start(OP_DIVU, 32'd7, 32'd0);
        wait_done(lat, dz, bc);
        check("divz_latency", 64'(lat), 64'd2);
        check("divz_flag", 64'(dz), 64'd1);
        check("divz_hilo", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
        @(negedge clk);
        check("divz_flag_pulse", 64'(bus.div_zero), 64'd0);

        // Signed overflow: most-negative / -1
        pulse_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, dz, bc);
        check("ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        check("ovf_dz", 64'(dz), 64'd0);

        // Unused op code behaves as NOP
        pulse_start(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
        check("nop13_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("nop13_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Abort mid-multiply
        pulse_start(OP_MTHI, 32'h1111, 32'd0);
        pulse_start(OP_MTLO, 32'h2222, 32'd0);
        pulse_start(OP_MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, {32'h1111, 32'h2222});

        // Start held high while busy (with a different op) is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.op    = OP_MTHI;
        bus.a     = 32'hDEAD;
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        wait_done(lat, dz, bc);
        check("held_start_hilo", {bus.hi, bus.lo}, {32'd0, 32'd42});

        // Asynchronous reset in the middle of a divide
        pulse_start(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset
        pulse_start(OP_MULTU, 32'd3, 32'd4);
        wait_done(lat, dz, bc);
        check("post_rst_hilo", {bus.hi, bus.lo}, 64'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine that owns the architectural HI/LO register pair for the MIPS core.
- Sits beside the ALU in EX. Driven by the 6-bit ALU control code space (MULT, MULTU, MADD, MSUB, MTHI, MTLO, MFHI, MFLO), extended with MADDU, MSUBU, DIV and DIVU.
- Replaces the single-cycle HI/LO handling with a parametrised iterative datapath that has a start/busy/done handshake for pipeline stalls.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request; sampled only when Busy=0.
- Op  in  4  operation code (package constants).
- A  in  WIDTH  rs operand / dividend.
- B  in  WIDTH  rt operand / divisor.
- Abort  in  1  pipeline flush; cancels an in-flight operation.
- Busy  out  1  high while an iterative operation is in flight; the core stalls MF*/MT*/new mul-div on Busy.
- Done  out  1  one-cycle pulse when HI/LO have been updated by an iterative operation.
- DivZero  out  1  one-cycle pulse coincident with Done for DIV/DIVU with B=0.
- Hi  out  WIDTH  HI register; this is the MFHI source.
- Lo  out  WIDTH  LO register; this is the MFLO source.

Behaviour:
Reset (Rst_n=0, asynchronous):
- Hi=0, Lo=0, Busy=0, Done=0, DivZero=0.
- state=IDLE, counter=0, internal shift registers cleared.

Op codes:
- NOP=0, MULT=1, MULTU=2, MADD=3, MADDU=4, MSUB=5, MSUBU=6, DIV=7, DIVU=8, MTHI=9, MTLO=10.
- Codes 11-15 are treated as NOP.

MTHI/MTLO:
- With Start=1 and Busy=0: Hi<=A (MTHI) or Lo<=A (MTLO) at the next edge.
- No Busy, no Done.

State machine: IDLE -> MUL | DIV -> FIX -> IDLE.

IDLE:
- On Start with a mul-class op: latch |A| and |B| (signed ops) or A and B raw (unsigned ops); record result-sign and op.
- Load counter=WIDTH and go to MUL. Busy rises at the same edge.
- On Start with a div-class op: same latch, then go to DIV.

MUL:
- Radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH partial product.
- Counter decrements each cycle; when counter reaches 1, go to FIX.

DIV:
- Restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- If B=0 is latched, skip iteration and go directly to FIX.

FIX (one cycle), applied in this order:
1. Sign correction: negate the product if signs differ. For divide, quotient sign = sign(A)^sign(B) and remainder sign = sign(A).
2. Accumulate: MADD/MADDU add the product to {Hi,Lo}; MSUB/MSUBU subtract it from {Hi,Lo}. Arithmetic is modulo 2^(2*WIDTH).
3. Write: {Hi,Lo} <= result for multiply; Hi<=remainder, Lo<=quotient for divide.
- Done=1 that cycle's output (registered), Busy falls, return to IDLE.

Latency and throughput:
- Start-to-Done is WIDTH+2 cycles (1 latch + WIDTH iterate + 1 FIX).
- Divide-by-zero is 2 cycles.
- A new Start is accepted in the cycle after Done.

Divide by zero:
- Hi<=A, Lo<=all ones, DivZero=1 together with Done.

Overflow case:
- Signed most-negative / -1 yields Lo=most-negative, Hi=0, with no flag. This falls out of the magnitude path.

Start while Busy=1:
- Ignored, with no effect on state.

Abort:
- Abort=1 in any state forces IDLE at the next edge, Busy=0.
- Hi/Lo are unchanged and no Done pulse is produced.
- If Abort and Start are both high in IDLE, Abort wins.

Reset mid-operation:
- Immediate return to reset values; the partial result is discarded.

Decomposition:
- Shared package hilo_pkg holds the Op code localparams, the state encoding (IDLE, MUL, DIV, FIX), and a helper function for two's-complement magnitude.
- One natural sub-module: muldiv_iter_core. It contains the shift-add/restoring datapath and the counter, with a load/step/finish interface.
- The top level owns the FSM, sign and accumulate logic, and the HI/LO registers.

Test Plan:
1. MULT A=0xFFFFFFFE (-2), B=3 -> Done at cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. Busy is high for cycles 1-33.
2. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
3. MTHI 5, MTLO 7, then MADD A=2, B=3 -> Hi=5, Lo=13. Repeat with MSUB A=2, B=3 starting from the same Hi=5, Lo=13 -> Hi=5, Lo=7.
4. DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU A=7, B=0 -> Done after 2 cycles with DivZero=1, Hi=7, Lo=0xFFFFFFFF.
5. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivZero=0.
6. Start MULT, then pulse Abort at cycle 10 -> Busy=0 next cycle, no Done, Hi/Lo keep prior values. Start held high while Busy -> ignored. Rst_n low mid-DIV -> all outputs 0 asynchronously.
